// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encodings and framing constants
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int OVERSAMPLE_DEF = 16;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: single-clock show-ahead FIFO holding received bytes
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);
    logic [ADDR_W:0] wr_ptr_q, rd_ptr_q;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic do_rd, do_wr;
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    // a pop on empty is ignored; a push while full only lands when a pop frees the slot
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign dout  = mem_q[rd_ptr_q[ADDR_W-1:0]];
    // advance pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
    // storage array, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[ADDR_W-1:0]] <= din;
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 oversampling UART receiver with framing/overrun flags and receive FIFO
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk_rf,
    input  logic                 rst_rf,
    input  logic                 rx_in,
    input  logic                 rf_rd,
    output logic [DATA_BITS-1:0] rf_dout,
    output logic                 rf_empty,
    output logic                 rf_full,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    rx_state_e state_q;
    logic sync_q, rx_s_q;
    logic [CW-1:0] cnt_q;
    logic [2:0] bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic frame_err_q, overrun_q;
    logic sample, wr_en;
    assign sample    = cnt_q == LAST;
    assign wr_en     = state_q == STOP && sample && rx_s_q && (!rf_full || rf_rd);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    // two-flop synchronizer for the asynchronous line, idle high
    always_ff @(posedge clk_rf) begin
        if (rst_rf) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q <= rx_in;
            rx_s_q <= sync_q;
        end
    end
    // frame FSM: start qualification at mid start bit, then one sample per bit period
    always_ff @(posedge clk_rf) begin
        if (rst_rf) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            case (state_q)
                IDLE: if (!rx_s_q) begin
                    state_q <= START;
                    cnt_q   <= '0;
                end
                START: if (cnt_q == HALF) begin
                    if (rx_s_q) state_q <= IDLE;
                    else begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end
                end else cnt_q <= cnt_q + 1'b1;
                DATA: begin
                    cnt_q <= sample ? '0 : cnt_q + 1'b1;
                    if (sample) begin
                        shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) state_q <= STOP;
                    end
                end
                STOP: begin
                    cnt_q <= sample ? '0 : cnt_q + 1'b1;
                    if (sample) begin
                        if (rx_s_q) begin
                            state_q   <= IDLE;
                            overrun_q <= rf_full && !rf_rd;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: if (rx_s_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk  (clk_rf),
        .rst  (rst_rf),
        .din  (shift_q),
        .wr_en(wr_en),
        .rd_en(rf_rd),
        .dout (rf_dout),
        .full (rf_full),
        .empty(rf_empty)
    );
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frame vectors and corner-case sequences for uart_receiver
`timescale 1ns/1ps
module tb_uart_receiver;
    logic clk_rf = 1'b0;
    logic rst_rf, rx_in, rf_rd;
    logic [7:0] rf_dout;
    logic rf_empty, rf_full, frame_err, overrun;
    int vectors = 0;
    int miscompares = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int both_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_wr;
        logic [7:0] exp_dout;
        logic       exp_ferr;
    } vec_t;
    vec_t vt [7];

    uart_receiver dut (
        .clk_rf   (clk_rf),
        .rst_rf   (rst_rf),
        .rx_in    (rx_in),
        .rf_rd    (rf_rd),
        .rf_dout  (rf_dout),
        .rf_empty (rf_empty),
        .rf_full  (rf_full),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk_rf = ~clk_rf;

    always @(negedge clk_rf) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_err && overrun) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (16) @(negedge clk_rf);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rx_in = 1'b1;
    endtask

    task automatic pop();
        rf_rd = 1'b1;
        @(negedge clk_rf);
        rf_rd = 1'b0;
    endtask

    initial begin
        int f0, o0;
        vt[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
        vt[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
        vt[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
        vt[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
        vt[5] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[6] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0};
        rst_rf = 1'b1;
        rx_in  = 1'b1;
        rf_rd  = 1'b0;
        repeat (3) @(negedge clk_rf);
        chk("reset empty", rf_empty, 1);
        chk("reset full", rf_full, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset overrun", overrun, 0);
        rst_rf = 1'b0;
        repeat (20) @(negedge clk_rf);

        // single byte with write-edge latency
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (154) @(posedge clk_rf);
                #1 chk("latency empty before write", rf_empty, 1);
                @(posedge clk_rf);
                #1 chk("latency empty after write", rf_empty, 0);
                chk("latency dout", rf_dout, 8'hA5);
            end
        join
        pop();
        chk("single pop empty", rf_empty, 1);
        repeat (10) @(negedge clk_rf);

        // table of frames
        for (int i = 0; i < 7; i++) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            send_frame(vt[i].data, vt[i].stop);
            if (!vt[i].stop) begin
                rx_in = 1'b0;
                repeat (40) @(negedge clk_rf);
                rx_in = 1'b1;
                repeat (16) @(negedge clk_rf);
            end
            chk($sformatf("vec%0d frame_err", i), ferr_cnt - f0, 32'(vt[i].exp_ferr));
            chk($sformatf("vec%0d overrun", i), ovr_cnt - o0, 0);
            chk($sformatf("vec%0d empty", i), rf_empty, !vt[i].exp_wr);
            if (vt[i].exp_wr) begin
                chk($sformatf("vec%0d dout", i), rf_dout, vt[i].exp_dout);
                pop();
            end
            chk($sformatf("vec%0d empty after", i), rf_empty, 1);
        end

        // glitch shorter than half a bit
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rx_in = 1'b0;
        repeat (4) @(negedge clk_rf);
        rx_in = 1'b1;
        repeat (40) @(negedge clk_rf);
        chk("glitch empty", rf_empty, 1);
        chk("glitch flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

        // 17 back-to-back bytes without reading
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 14) chk("overrun not full at 15", rf_full, 0);
            if (i == 15) chk("overrun full at 16", rf_full, 1);
        end
        repeat (4) @(negedge clk_rf);
        chk("overrun pulses", ovr_cnt - o0, 1);
        chk("overrun no frame_err", ferr_cnt - f0, 0);
        chk("overrun still full", rf_full, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain %0d", i), rf_dout, 32'(i));
            pop();
        end
        chk("drain empty", rf_empty, 1);

        // push and pop at the stop sample while full
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
        chk("refill full", rf_full, 1);
        o0 = ovr_cnt;
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (154) @(posedge clk_rf);
                @(negedge clk_rf);
                rf_rd = 1'b1;
                @(negedge clk_rf);
                rf_rd = 1'b0;
                chk("fullpop still full", rf_full, 1);
                chk("fullpop head", rf_dout, 8'h01);
            end
        join
        repeat (4) @(negedge clk_rf);
        chk("fullpop no overrun", ovr_cnt - o0, 0);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("fullpop drain %0d", i), rf_dout, 32'(i));
            pop();
        end
        chk("fullpop last", rf_dout, 8'h55);
        chk("fullpop not empty", rf_empty, 0);
        pop();
        chk("fullpop empty", rf_empty, 1);

        // reset during bit 4 of 0xFF
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (8) @(negedge clk_rf);
        rst_rf = 1'b1;
        repeat (2) @(negedge clk_rf);
        rst_rf = 1'b0;
        repeat (100) @(negedge clk_rf);
        chk("midreset empty", rf_empty, 1);
        chk("midreset flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        send_frame(8'h12, 1'b1);
        chk("midreset next empty", rf_empty, 0);
        chk("midreset next dout", rf_dout, 8'h12);
        pop();

        chk("flags never coincide", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
